// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU instruction sequencer slice:
//   - opcode constants OPC_ADD .. OPC_MOV (3-bit)
//   - FSM state encoding (IDLE=0, READ=1, EXEC=2, WB=3)
//   - flag vector width and bit indices {N,Z,C,V}
//   - opcode decode helpers (flag-setting / writeback / flag capture)
// Optional feature macro: ARITH_FLAGS_EN (ADD/SUB/RSB also capture flags).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_RSB = 3'b010;
    localparam logic [2:0] OPC_AND = 3'b011;
    localparam logic [2:0] OPC_NOT = 3'b100;
    localparam logic [2:0] OPC_TST = 3'b101;
    localparam logic [2:0] OPC_CMP = 3'b110;
    localparam logic [2:0] OPC_MOV = 3'b111;

    localparam int FLAG_BITS = 4;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_t;

    // TST and CMP only set flags; they never write a result back.
    function automatic logic is_flag_op(input logic [2:0] op);
        return (op == OPC_TST) || (op == OPC_CMP);
    endfunction

    function automatic logic is_wb_op(input logic [2:0] op);
        return !is_flag_op(op);
    endfunction

    // Which opcodes load the architectural flags during EXEC.
    function automatic logic captures_flags(input logic [2:0] op);
`ifdef ARITH_FLAGS_EN
        return is_flag_op(op) || (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_RSB);
`else
        return is_flag_op(op);
`endif
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// ----------------------------------------------------------------------------
// alu_flag_reg
// Architectural flag register {N,Z,C,V} with asynchronous active-low clear
// and a synchronous load enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low clear (flags -> 0)
//   ld   - load enable, q <= d on the next rising edge
//   d    - next flag value
//   q    - current flag value
// ----------------------------------------------------------------------------
module alu_flag_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// ----------------------------------------------------------------------------
// alu_instr_sequencer
// Multicycle control FSM sequencing one ALU instruction at a time through
// register read, ALU execute, writeback and flag capture.
//   Writeback ops (ADD SUB RSB AND NOT MOV): IDLE -> READ -> EXEC -> WB -> IDLE
//   Flag ops (TST CMP):                      IDLE -> READ -> EXEC -> IDLE
// Optional feature macro: ARITH_FLAGS_EN (ADD/SUB/RSB also capture flags).
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   issue_valid/ready   - instruction handshake (ready only in IDLE)
//   opc, rd, rs1, rs2   - instruction fields, latched on accept
//   rf_ra1/ra2, rf_re   - register-file read addresses and strobe
//   rf_wa, rf_we        - register-file write address and enable
//   alu_op, res_ld      - ALU operation select and result latch strobe
//   alu_flags           - raw ALU flags, sampled at the end of EXEC
//   flags               - architectural flag register {N,Z,C,V}
//   done                - one-cycle completion pulse
// ----------------------------------------------------------------------------
module alu_instr_sequencer
    import alu_pkg::*;
#(
    parameter int RADDR_W = 3,
    parameter int FLAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [2:0]         opc,
    input  logic [RADDR_W-1:0] rd,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    output logic [RADDR_W-1:0] rf_ra1,
    output logic [RADDR_W-1:0] rf_ra2,
    output logic               rf_re,
    output logic [RADDR_W-1:0] rf_wa,
    output logic               rf_we,
    output logic [2:0]         alu_op,
    output logic               res_ld,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [FLAG_W-1:0]  flags,
    output logic               done
);

    seq_state_t         state;
    logic [2:0]         opc_q;
    logic [RADDR_W-1:0] rd_q;
    logic [RADDR_W-1:0] rs1_q;
    logic [RADDR_W-1:0] rs2_q;
    logic               flag_ld;

    // Register addresses simply mirror the latched instruction fields, so
    // they hold their last values between instructions.
    assign rf_ra1      = rs1_q;
    assign rf_ra2      = rs2_q;
    assign rf_wa       = rd_q;
    assign issue_ready = (state == IDLE);

    // Flags are loaded at the end of EXEC; an async reset during EXEC
    // removes the load before any edge can commit it.
    assign flag_ld = (state == EXEC) && captures_flags(opc_q);

    // Sequencer FSM. Strobe outputs are registered: each transition sets
    // the outputs that belong to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            opc_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rf_re  <= 1'b0;
            rf_we  <= 1'b0;
            res_ld <= 1'b0;
            done   <= 1'b0;
            alu_op <= OPC_ADD;
        end else begin
            case (state)
                IDLE: begin
                    rf_we  <= 1'b0;
                    res_ld <= 1'b0;
                    done   <= 1'b0;
                    alu_op <= OPC_ADD;
                    if (issue_valid) begin
                        opc_q <= opc;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        rf_re <= 1'b1;
                        state <= READ;
                    end else begin
                        rf_re <= 1'b0;
                    end
                end
                READ: begin
                    rf_re  <= 1'b0;
                    alu_op <= opc_q;
                    res_ld <= 1'b1;
                    // Flag ops complete in EXEC, so done rises with it.
                    done   <= is_flag_op(opc_q);
                    state  <= EXEC;
                end
                EXEC: begin
                    alu_op <= OPC_ADD;
                    res_ld <= 1'b0;
                    if (is_wb_op(opc_q)) begin
                        rf_we <= 1'b1;
                        done  <= 1'b1;
                        state <= WB;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WB: begin
                    rf_we <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    rf_re  <= 1'b0;
                    rf_we  <= 1'b0;
                    res_ld <= 1'b0;
                    done   <= 1'b0;
                    alu_op <= OPC_ADD;
                    state  <= IDLE;
                end
            endcase
        end
    end

    alu_flag_reg #(
        .W (FLAG_W)
    ) u_flag_reg (
        .clk (clk),
        .rst (rst),
        .ld  (flag_ld),
        .d   (alu_flags),
        .q   (flags)
    );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_instr_sequencer
// Self-checking bench for alu_instr_sequencer: a table of single-instruction
// vectors walked cycle by cycle, plus hand-written sequences for back-to-back
// issue and reset during EXEC. Honours ARITH_FLAGS_EN if defined.
// ----------------------------------------------------------------------------
module tb_alu_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [2:0] opc = 3'd0;
    logic [2:0] rd = 3'd0;
    logic [2:0] rs1 = 3'd0;
    logic [2:0] rs2 = 3'd0;
    logic [2:0] rf_ra1;
    logic [2:0] rf_ra2;
    logic       rf_re;
    logic [2:0] rf_wa;
    logic       rf_we;
    logic [2:0] alu_op;
    logic       res_ld;
    logic [3:0] alu_flags = 4'd0;
    logic [3:0] flags;
    logic       done;

    int testCount = 0;
    int failCount = 0;

`ifdef ARITH_FLAGS_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    typedef struct {
        logic [2:0] opc;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] aflags;
        logic       wb;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs[8];

    alu_instr_sequencer #(
        .RADDR_W (3),
        .FLAG_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opc         (opc),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_re       (rf_re),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .res_ld      (res_ld),
        .alu_flags   (alu_flags),
        .flags       (flags),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [2:0] d,
                                 input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [3:0] af);
        opc       = o;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        alu_flags = af;
    endtask

    initial begin
        // Expected flags are tracked by hand: default build vs ARITH_FLAGS_EN.
        vecs[0] = '{3'b000, 3'd2, 3'd1, 3'd3, 4'b1100, 1'b1, ARITH ? 4'b1100 : 4'b0000}; // ADD
        vecs[1] = '{3'b110, 3'd0, 3'd4, 3'd5, 4'b0100, 1'b0, 4'b0100};                    // CMP
        vecs[2] = '{3'b001, 3'd6, 3'd7, 3'd2, 4'b1010, 1'b1, ARITH ? 4'b1010 : 4'b0100}; // SUB
        vecs[3] = '{3'b011, 3'd1, 3'd2, 3'd3, 4'b0011, 1'b1, ARITH ? 4'b1010 : 4'b0100}; // AND
        vecs[4] = '{3'b101, 3'd5, 3'd3, 3'd6, 4'b1001, 1'b0, 4'b1001};                    // TST
        vecs[5] = '{3'b100, 3'd7, 3'd5, 3'd0, 4'b0110, 1'b1, 4'b1001};                    // NOT
        vecs[6] = '{3'b010, 3'd3, 3'd6, 3'd1, 4'b0001, 1'b1, ARITH ? 4'b0001 : 4'b1001}; // RSB
        vecs[7] = '{3'b111, 3'd4, 3'd2, 3'd7, 4'b1111, 1'b1, ARITH ? 4'b0001 : 4'b1001}; // MOV

        // Reset state
        #3;
        checkOutput("rst_issue_ready", issue_ready, 1);
        checkOutput("rst_rf_re", rf_re, 0);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_res_ld", res_ld, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_flags", flags, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Table-driven single instructions
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].aflags);
            checkOutput($sformatf("v%0d_ready_idle", i), issue_ready, 1);
            issue_valid = 1'b1;
            tick();
            issue_valid = 1'b0;
            // READ
            checkOutput($sformatf("v%0d_read_rf_re", i), rf_re, 1);
            checkOutput($sformatf("v%0d_read_ra1", i), rf_ra1, vecs[i].rs1);
            checkOutput($sformatf("v%0d_read_ra2", i), rf_ra2, vecs[i].rs2);
            checkOutput($sformatf("v%0d_read_alu_op", i), alu_op, 0);
            checkOutput($sformatf("v%0d_read_ready", i), issue_ready, 0);
            checkOutput($sformatf("v%0d_read_done", i), done, 0);
            tick();
            // EXEC
            checkOutput($sformatf("v%0d_exec_alu_op", i), alu_op, vecs[i].opc);
            checkOutput($sformatf("v%0d_exec_res_ld", i), res_ld, 1);
            checkOutput($sformatf("v%0d_exec_rf_re", i), rf_re, 0);
            checkOutput($sformatf("v%0d_exec_rf_we", i), rf_we, 0);
            checkOutput($sformatf("v%0d_exec_done", i), done, !vecs[i].wb);
            tick();
            if (vecs[i].wb) begin
                // WB
                checkOutput($sformatf("v%0d_wb_rf_we", i), rf_we, 1);
                checkOutput($sformatf("v%0d_wb_rf_wa", i), rf_wa, vecs[i].rd);
                checkOutput($sformatf("v%0d_wb_done", i), done, 1);
                checkOutput($sformatf("v%0d_wb_alu_op", i), alu_op, 0);
                checkOutput($sformatf("v%0d_wb_res_ld", i), res_ld, 0);
                tick();
            end
            checkOutput($sformatf("v%0d_end_ready", i), issue_ready, 1);
            checkOutput($sformatf("v%0d_end_rf_we", i), rf_we, 0);
            checkOutput($sformatf("v%0d_end_done", i), done, 0);
            checkOutput($sformatf("v%0d_end_flags", i), flags, vecs[i].expFlags);
        end

        // Back-to-back MOV then TST with issue_valid held high; TST fields
        // are presented while MOV is in flight and must wait for IDLE.
        applyStimulus(3'b111, 3'd6, 3'd1, 3'd2, 4'b0000);
        issue_valid = 1'b1;
        tick();
        applyStimulus(3'b101, 3'd0, 3'd5, 3'd3, 4'b0110);
        tick();
        tick();
        checkOutput("b2b_mov_done", done, 1);
        checkOutput("b2b_mov_wa", rf_wa, 6);
        checkOutput("b2b_wb_ready", issue_ready, 0);
        tick();
        checkOutput("b2b_idle_ready", issue_ready, 1);
        checkOutput("b2b_idle_no_accept", rf_re, 0);
        tick();
        issue_valid = 1'b0;
        checkOutput("b2b_tst_rf_re", rf_re, 1);
        checkOutput("b2b_tst_ra1", rf_ra1, 5);
        checkOutput("b2b_tst_ra2", rf_ra2, 3);
        tick();
        checkOutput("b2b_tst_alu_op", alu_op, 3'b101);
        checkOutput("b2b_tst_done", done, 1);
        tick();
        checkOutput("b2b_tst_flags", flags, 4'b0110);
        checkOutput("b2b_tst_no_we", rf_we, 0);
        checkOutput("b2b_end_ready", issue_ready, 1);

        // Reset pulsed low during EXEC of AND: flags must clear, no writeback.
        applyStimulus(3'b011, 3'd5, 3'd1, 3'd4, 4'b1111);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        checkOutput("rstx_in_exec", res_ld, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstx_ready", issue_ready, 1);
        checkOutput("rstx_res_ld", res_ld, 0);
        checkOutput("rstx_flags", flags, 0);
        tick();
        checkOutput("rstx_no_we_held", rf_we, 0);
        checkOutput("rstx_flags_held", flags, 0);
        rst = 1'b1;
        tick();
        checkOutput("rstx_post_we", rf_we, 0);
        checkOutput("rstx_post_ready", issue_ready, 1);
        checkOutput("rstx_post_done", done, 0);
        checkOutput("rstx_post_flags", flags, 0);
        tick();
        checkOutput("rstx_post_we2", rf_we, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
